// File: rtl/lockstep_pkg.sv
// Shared types and constants for the counter lockstep monitor and its step checker.
//   mon_state_e     : monitor FSM state encoding (ARM, CHECK, SUSPECT, FAULT)
//   CAUSE_DIS_BIT   : fault_cause bit for a primary/shadow disagreement
//   CAUSE_STEP_BIT  : fault_cause bit for a counter step that did not follow enable
//   DEFAULT_WIDTH   : default counter width
package lockstep_pkg;

  typedef enum logic [1:0] {
    ARM     = 2'd0,
    CHECK   = 2'd1,
    SUSPECT = 2'd2,
    FAULT   = 2'd3
  } mon_state_e;

  localparam int CAUSE_DIS_BIT  = 0;
  localparam int CAUSE_STEP_BIT = 1;
  localparam int DEFAULT_WIDTH  = 8;

endpackage

// File: rtl/lockstep_step_check.sv
// Combinational compare of a redundant counter pair against the previous sample.
// This block is also intended for reuse by the PC-lockstep comparator.
// Ports:
//   prev_cnt : primary counter value registered on the previous edge
//   prev_en  : enable registered on the previous edge
//   cnt_a    : current primary counter value
//   cnt_b    : current shadow counter value
//   dis      : primary and shadow disagree
//   step     : primary did not advance as prev_en dictated (modulo 2^WIDTH)
module lockstep_step_check #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] prev_cnt,
  input  logic             prev_en,
  input  logic [WIDTH-1:0] cnt_a,
  input  logic [WIDTH-1:0] cnt_b,
  output logic             dis,
  output logic             step
);

  logic [WIDTH-1:0] exp_cnt;

  // The addition wraps naturally at the top of the range.
  assign exp_cnt = prev_en ? prev_cnt + WIDTH'(1) : prev_cnt;
  assign dis     = (cnt_a != cnt_b);
  assign step    = (cnt_a != exp_cnt);

endmodule

// File: rtl/counter_lockstep_monitor.sv
// Lockstep monitor for a primary/shadow counter pair. Every cycle it checks
// that both counters agree and that they advanced exactly as the shared
// enable of the previous cycle dictated. MISMATCH_LIMIT consecutive
// violating cycles latch a sticky fault, released only by clear_fault.
// Optional build macro: LOCKSTEP_ERRCNT_EN adds a saturating err_count output.
// Ports:
//   clk         : system clock, rising edge
//   reset       : asynchronous active-low reset
//   enable      : enable shared by both counters
//   cnt_a       : primary counter value
//   cnt_b       : shadow counter value
//   clear_fault : single-cycle pulse that releases a latched fault
//   check_valid : comparison result is meaningful this cycle
//   fault       : sticky fault flag
//   fault_cause : bit0 disagreement, bit1 illegal step (OR over the violating run)
//   err_count   : (LOCKSTEP_ERRCNT_EN only) saturating count of violating cycles
module counter_lockstep_monitor
  import lockstep_pkg::*;
#(
  parameter int WIDTH          = DEFAULT_WIDTH,
  parameter int MISMATCH_LIMIT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] cnt_a,
  input  logic [WIDTH-1:0] cnt_b,
  input  logic             clear_fault,
  output logic             check_valid,
  output logic             fault,
  output logic [1:0]       fault_cause
`ifdef LOCKSTEP_ERRCNT_EN
  ,
  output logic [7:0]       err_count
`endif
);

  localparam logic [3:0] LIMIT = 4'(MISMATCH_LIMIT);

  mon_state_e       state;
  logic [3:0]       run;
  logic [3:0]       run_next;
  logic [1:0]       pend_cause;
  logic [1:0]       cause_now;
  logic [WIDTH-1:0] prev_cnt;
  logic             prev_en;
  logic             dis;
  logic             step;
  logic             viol;

  lockstep_step_check #(.WIDTH(WIDTH)) u_step_check (
    .prev_cnt (prev_cnt),
    .prev_en  (prev_en),
    .cnt_a    (cnt_a),
    .cnt_b    (cnt_b),
    .dis      (dis),
    .step     (step)
  );

  // check_valid is high exactly in CHECK and SUSPECT, so it gates the verdict.
  assign viol     = check_valid & (dis | step);
  assign run_next = run + 4'd1;

  always_comb begin
    cause_now                 = 2'b00;
    cause_now[CAUSE_DIS_BIT]  = dis;
    cause_now[CAUSE_STEP_BIT] = step;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ARM;
      run         <= 4'd0;
      pend_cause  <= 2'b00;
      prev_cnt    <= '0;
      prev_en     <= 1'b0;
      check_valid <= 1'b0;
      fault       <= 1'b0;
      fault_cause <= 2'b00;
    end else begin
      prev_cnt <= cnt_a;
      prev_en  <= enable;
      case (state)
        ARM: begin
          state       <= CHECK;
          check_valid <= 1'b1;
          run         <= 4'd0;
          pend_cause  <= 2'b00;
        end
        CHECK: begin
          if (viol) begin
            if (LIMIT == 4'd1) begin
              state       <= FAULT;
              check_valid <= 1'b0;
              fault       <= 1'b1;
              fault_cause <= cause_now;
            end else begin
              state      <= SUSPECT;
              run        <= 4'd1;
              pend_cause <= cause_now;
            end
          end
        end
        SUSPECT: begin
          if (!viol) begin
            state      <= CHECK;
            run        <= 4'd0;
            pend_cause <= 2'b00;
          end else if (run_next >= LIMIT) begin
            // A clear_fault arriving now is ignored: the fault must land first.
            state       <= FAULT;
            check_valid <= 1'b0;
            fault       <= 1'b1;
            fault_cause <= pend_cause | cause_now;
            run         <= 4'd0;
            pend_cause  <= 2'b00;
          end else begin
            run        <= run_next;
            pend_cause <= pend_cause | cause_now;
          end
        end
        FAULT: begin
          if (clear_fault) begin
            state       <= ARM;
            fault       <= 1'b0;
            fault_cause <= 2'b00;
          end
        end
        default: begin
          state       <= ARM;
          check_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef LOCKSTEP_ERRCNT_EN
  // Survives clear_fault on purpose: it is a lifetime health indicator.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_count <= 8'd0;
    end else if (viol && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_counter_lockstep_monitor.sv
module tb_counter_lockstep_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] cnt_a;
  logic [7:0] cnt_b;
  logic       clear_fault;
  logic       check_valid;
  logic       fault;
  logic [1:0] fault_cause;
`ifdef LOCKSTEP_ERRCNT_EN
  logic [7:0] err_count;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  counter_lockstep_monitor #(.WIDTH(8), .MISMATCH_LIMIT(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .cnt_a       (cnt_a),
    .cnt_b       (cnt_b),
    .clear_fault (clear_fault),
    .check_valid (check_valid),
    .fault       (fault),
    .fault_cause (fault_cause)
`ifdef LOCKSTEP_ERRCNT_EN
    ,
    .err_count   (err_count)
`endif
  );

  task automatic check(input string tag, input logic exp_cv, input logic exp_f,
                       input logic [1:0] exp_cause);
    total++;
    assert (check_valid === exp_cv) else begin
      bad++;
      $error("FAIL %s check_valid observed=%b expected=%b", tag, check_valid, exp_cv);
    end
    total++;
    assert (fault === exp_f) else begin
      bad++;
      $error("FAIL %s fault observed=%b expected=%b", tag, fault, exp_f);
    end
    total++;
    assert (fault_cause === exp_cause) else begin
      bad++;
      $error("FAIL %s fault_cause observed=%b expected=%b", tag, fault_cause, exp_cause);
    end
  endtask

  task automatic check_errcnt(input string tag, input logic [7:0] exp_n);
`ifdef LOCKSTEP_ERRCNT_EN
    total++;
    assert (err_count === exp_n) else begin
      bad++;
      $error("FAIL %s err_count observed=%0d expected=%0d", tag, err_count, exp_n);
    end
`else
    if (exp_n == 8'hFF) $display("%s unused", tag);
`endif
  endtask

  // Present inputs for the next rising edge, then sample just after it.
  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic en,
                       input logic clr);
    cnt_a       = a;
    cnt_b       = b;
    enable      = en;
    clear_fault = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_pulse", 1'b0, 1'b0, 2'b00);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset       = 1'b0;
    enable      = 1'b0;
    cnt_a       = 8'd0;
    cnt_b       = 8'd0;
    clear_fault = 1'b0;
    #1;
    check("reset_state", 1'b0, 1'b0, 2'b00);
    check_errcnt("reset_errcnt", 8'd0);
    @(negedge clk);
    reset = 1'b1;

    // ARM edge absorbs 0; checks begin on the following edge.
    drive(8'd0, 8'd0, 1'b1, 1'b0);
    check("arm_to_check", 1'b1, 1'b0, 2'b00);
    for (int i = 1; i <= 8; i++) begin
      // clear_fault outside FAULT must not disturb checking.
      drive(8'(i), 8'(i), 1'b1, (i == 4));
      check("count_up", 1'b1, 1'b0, 2'b00);
    end

    // Single-cycle disagreement: SUSPECT then back to CHECK, no fault.
    drive(8'd9, 8'd8, 1'b1, 1'b0);
    check("single_mis", 1'b1, 1'b0, 2'b00);
    drive(8'd10, 8'd10, 1'b1, 1'b0);
    check("single_recover", 1'b1, 1'b0, 2'b00);
    check_errcnt("errcnt_single", 8'd1);

    // Two consecutive disagreements; clear on the limit cycle loses to the fault.
    drive(8'd11, 8'd10, 1'b1, 1'b0);
    check("dis_first", 1'b1, 1'b0, 2'b00);
    drive(8'd12, 8'd13, 1'b1, 1'b1);
    check("dis_fault", 1'b0, 1'b1, 2'b01);
    check_errcnt("errcnt_dis", 8'd3);
    drive(8'd1, 8'd200, 1'b1, 1'b0);
    check("fault_sticky", 1'b0, 1'b1, 2'b01);
    check_errcnt("errcnt_in_fault", 8'd3);
    drive(8'd0, 8'd0, 1'b0, 1'b1);
    check("clear_to_arm", 1'b0, 1'b0, 2'b00);

    // Glitch: counters move 5->6->7 with enable low.
    drive(8'd5, 8'd5, 1'b0, 1'b0);
    check("arm_after_clear", 1'b1, 1'b0, 2'b00);
    drive(8'd6, 8'd6, 1'b0, 1'b0);
    check("glitch_first", 1'b1, 1'b0, 2'b00);
    drive(8'd7, 8'd7, 1'b0, 1'b0);
    check("glitch_fault", 1'b0, 1'b1, 2'b10);
    check_errcnt("errcnt_glitch", 8'd5);
    drive(8'd0, 8'd0, 1'b0, 1'b1);
    check("clear_glitch", 1'b0, 1'b0, 2'b00);

    // Legal wrap 255 -> 0.
    drive(8'd254, 8'd254, 1'b1, 1'b0);
    check("wrap_arm", 1'b1, 1'b0, 2'b00);
    drive(8'd255, 8'd255, 1'b1, 1'b0);
    check("wrap_255", 1'b1, 1'b0, 2'b00);
    drive(8'd0, 8'd0, 1'b1, 1'b0);
    check("wrap_0", 1'b1, 1'b0, 2'b00);
    check_errcnt("errcnt_wrap", 8'd5);

    // Illegal 255 -> 255 with enable high, twice in a row.
    pulse_reset();
    check_errcnt("errcnt_after_reset", 8'd0);
    drive(8'd255, 8'd255, 1'b1, 1'b0);
    check("stuck_arm", 1'b1, 1'b0, 2'b00);
    drive(8'd255, 8'd255, 1'b1, 1'b0);
    check("stuck_first", 1'b1, 1'b0, 2'b00);
    drive(8'd255, 8'd255, 1'b1, 1'b0);
    check("stuck_fault", 1'b0, 1'b1, 2'b10);

    // Async reset while in SUSPECT.
    pulse_reset();
    drive(8'd3, 8'd3, 1'b1, 1'b0);
    check("susp_arm", 1'b1, 1'b0, 2'b00);
    drive(8'd3, 8'd2, 1'b1, 1'b0);
    check("susp_enter", 1'b1, 1'b0, 2'b00);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("async_rst_suspect", 1'b0, 1'b0, 2'b00);
    @(negedge clk);
    reset = 1'b1;

    // Both causes in one run, then async reset while in FAULT.
    drive(8'd3, 8'd3, 1'b1, 1'b0);
    check("both_arm", 1'b1, 1'b0, 2'b00);
    drive(8'd4, 8'd5, 1'b1, 1'b0);
    check("both_first", 1'b1, 1'b0, 2'b00);
    drive(8'd9, 8'd9, 1'b1, 1'b0);
    check("both_fault", 1'b0, 1'b1, 2'b11);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("async_rst_fault", 1'b0, 1'b0, 2'b00);
    @(negedge clk);
    reset = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/counter_lockstep_monitor.md
Name: counter_lockstep_monitor

Overview:
- Downstream consumer of the 8-bit `up_counter`; sits between two redundant counter instances (primary A, shadow B) and the core fault-handling logic.
- Every cycle it checks that A and B agree.
- It also checks that their value advanced exactly as the shared `enable` dictated.
- A persistent violation raises a sticky `fault` that the glitch-protection controller uses to halt or reset the dual core.

Parameters:
- WIDTH, 8: counter width in bits; all arithmetic is modulo 2^WIDTH.
- MISMATCH_LIMIT, 2: consecutive violating cycles needed to declare a fault; legal range 1..15.

Ports:
- clk  input  1  system clock; rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  the same enable that drives both counters.
- cnt_a  input  WIDTH  `out` of the primary counter.
- cnt_b  input  WIDTH  `out` of the shadow counter.
- clear_fault  input  1  single-cycle pulse; releases a latched fault.
- check_valid  output  1  high in cycles where a comparison result is meaningful.
- fault  output  1  sticky fault flag.
- fault_cause  output  2  bit0 = A/B disagreement, bit1 = illegal step; latched together with `fault`.

Behaviour:
- Reset (reset low, asynchronous): state=ARM, fault=0, fault_cause=0, check_valid=0, internal run counter=0, prev_cnt=0, prev_en=0.
- Registered sampling:
  - Each rising edge registers prev_cnt<=cnt_a and prev_en<=enable.
  - The counters update one cycle after `enable` is sampled, so the cycle-N check uses enable from cycle N-1.
- Expected value: exp = prev_en ? prev_cnt+1 (wraps 255->0 at WIDTH=8) : prev_cnt.
- Violation in a cycle, when check_valid=1:
  - dis = (cnt_a != cnt_b)
  - step = (cnt_a != exp)
  - viol = dis | step
- FSM states ARM, CHECK, SUSPECT, FAULT:
  - ARM: one cycle after reset release or fault clear. Captures prev_* only, check_valid=0. Always goes to CHECK.
  - CHECK: check_valid=1.
    - No viol: stay in CHECK.
    - viol with MISMATCH_LIMIT=1: go to FAULT.
    - viol otherwise: go to SUSPECT with run=1; accumulate cause bits.
  - SUSPECT: check_valid=1.
    - No viol: back to CHECK, run=0, pending cause cleared.
    - viol: run+1 and OR the cause bits; when run reaches MISMATCH_LIMIT, go to FAULT.
  - FAULT: fault=1, fault_cause holds the OR of all causes in the violating run, check_valid=0.
    - Inputs are ignored.
    - clear_fault=1 goes to ARM with fault and fault_cause cleared on the same edge.
- `fault` and `fault_cause` are registered outputs: asserted on the edge that enters FAULT, never combinational.
- clear_fault outside FAULT: no effect.
- clear_fault in the same cycle as the violation that would reach the limit: the fault wins; clear applies only in FAULT.
- Wrap-around: 255 with prev_en=1 followed by 0 is legal; 255 followed by 255 with prev_en=1 is a step violation.
- Reset asserted mid-SUSPECT or mid-FAULT: immediate return to the reset values.
- Counter reset concurrent with monitor reset: the ARM cycle absorbs the first post-reset value, so there are no false faults.

Optional Feature:
- Macro: LOCKSTEP_ERRCNT_EN.
- With the macro defined:
  - Extra output `err_count`, 8 bits: a saturating count of violating cycles, each cycle with viol=1 while check_valid=1.
  - Holds at 255 once saturated.
  - Cleared only by reset; clear_fault does not clear it.
  - Counting continues through SUSPECT; FAULT cycles are not counted.
- Without the macro: no port, no logic; behaviour is otherwise identical.

Decomposition:
- Shared package `lockstep_pkg`:
  - enum mon_state_e {ARM, CHECK, SUSPECT, FAULT}.
  - localparams CAUSE_DIS_BIT=0 and CAUSE_STEP_BIT=1.
  - Default WIDTH=8.
- One sub-module `lockstep_step_check`:
  - Purely combinational: inputs prev_cnt, prev_en, cnt_a, cnt_b.
  - Outputs dis and step.
  - Reusable for the PC-lockstep comparator.
- FSM, run counter and optional err_count stay in the top module.

Test Plan:
- Reset, then enable=1 for 8 cycles with matching counters 0..8 -> check_valid=1 from the 2nd cycle after reset release, fault=0 throughout.
- Force cnt_b=cnt_a^8'h01 for 1 cycle, MISMATCH_LIMIT=2 -> state goes to SUSPECT and back to CHECK, fault stays 0; err_count=1 if LOCKSTEP_ERRCNT_EN.
- Force cnt_b mismatch for 2 consecutive cycles -> fault=1 on the 2nd violating edge, fault_cause=2'b01; then clear_fault pulse -> fault=0 next edge, ARM, then CHECK.
- enable=0 while both counters jump 5->6 (glitch), held 2 cycles -> fault=1, fault_cause=2'b10.
- Counters at 255 with enable=1, next value 0 -> no violation; the same case with next value 255 -> step violation.
- Assert reset low asynchronously mid-SUSPECT (between clock edges) -> fault, check_valid and fault_cause go to 0 immediately, without waiting for a clock edge.
